// File: rtl/div_sequencer_if.sv
// Start/done handshake plus operand and result buses between the control unit and the
// iterative divider.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, div_zero, quotient, remainder
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, div_zero, quotient, remainder
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative non-restoring divider for DIV/DIVU: one quotient bit per clock through a single
// shared adder/subtractor; quotient goes to LO, remainder to HI.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_signed;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_sd;
    logic             w_sv;
    logic [WIDTH-1:0] w_abs_dividend;
    logic [WIDTH-1:0] w_abs_divisor;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_add_in;
    logic [WIDTH:0]   w_operand;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_rem_mag;

    // The one adder serves both ITER (shifted A +/- M) and FIXUP (A + M restore).
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        w_sd           = r_signed & r_dividend[WIDTH-1];
        w_sv           = r_signed & r_divisor[WIDTH-1];
        w_abs_dividend = w_sd ? -r_dividend : r_dividend;
        w_abs_divisor  = w_sv ? -r_divisor : r_divisor;
        w_a_shift      = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
        w_sub          = (r_state == S_ITER) && !r_a[WIDTH];
        w_add_in       = (r_state == S_ITER) ? w_a_shift : r_a;
        w_operand      = w_sub ? ~r_m : r_m;
        w_sum          = w_add_in + w_operand + {{WIDTH{1'b0}}, w_sub};
        w_rem_mag      = r_a[WIDTH] ? w_sum[WIDTH-1:0] : r_a[WIDTH-1:0];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_signed    <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            r_a         <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_signed   <= bus.is_signed;
                        r_dividend <= bus.dividend;
                        r_divisor  <= bus.divisor;
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_sign_q <= w_sd ^ w_sv;
                    r_sign_r <= w_sd;
                    r_q      <= w_abs_dividend;
                    r_m      <= {1'b0, w_abs_divisor};
                    r_a      <= '0;
                    r_count  <= '0;
                    r_zero   <= (r_divisor == '0);
                    // A zero divisor skips the iterations and is resolved in FIXUP.
                    r_state  <= (r_divisor == '0) ? S_FIXUP : S_ITER;
                end
                S_ITER: begin
                    r_a <= w_sum;
                    r_q <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_count <= '0;
                        r_state <= S_FIXUP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_FIXUP: begin
                    if (r_zero) begin
                        r_quotient  <= '0;
                        r_remainder <= r_dividend;
                        r_div_zero  <= 1'b1;
                    end else begin
                        r_quotient  <= r_sign_q ? -r_q : r_q;
                        r_remainder <= r_sign_r ? -w_rem_mag : w_rem_mag;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.div_zero  = r_div_zero;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus random operands against
// a plain-arithmetic reference model.
module tb_div_sequencer;
    logic clk;
    logic clr;
    int   checks;
    int   errors;
    logic [31:0] prev_q;
    logic [31:0] prev_r;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clock (clk),
        .clear (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer division truncates toward zero, and % takes the dividend's sign.
    function automatic void model(input logic sgn, input logic [31:0] dd, input logic [31:0] dv,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint a;
        longint b;
        longint lq;
        longint lr;
        if (dv == 32'd0) begin
            q = 32'd0;
            r = dd;
            z = 1'b1;
            return;
        end
        z = 1'b0;
        if (sgn) begin
            a = $signed(dd);
            b = $signed(dv);
        end else begin
            a = {32'd0, dd};
            b = {32'd0, dv};
        end
        lq = a / b;
        lr = a % b;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // One operation from start to done; poke_at >= 0 re-asserts start mid-operation.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] dd,
                          input logic [31:0] dv, input int poke_at);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          n;
        int          bad_busy;
        int          exp_lat;
        model(sgn, dd, dv, eq, er, ez);
        exp_lat = ez ? 2 : 34;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = dd;
        bus.divisor   = dv;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        check({tag, "_dz_cleared"}, bus.div_zero, 1'b0);
        check({tag, "_hold_q"}, bus.quotient, prev_q);
        check({tag, "_hold_r"}, bus.remainder, prev_r);
        n        = 0;
        bad_busy = 0;
        while (!bus.done && n < 100) begin
            if (!bus.busy) bad_busy++;
            bus.start = (n == poke_at);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_gaps"}, bad_busy, 0);
        check({tag, "_busy_at_done"}, bus.busy, 1'b0);
        check({tag, "_quotient"}, bus.quotient, eq);
        check({tag, "_remainder"}, bus.remainder, er);
        check({tag, "_div_zero"}, bus.div_zero, ez);
        // start while in DONE must be ignored
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_done_ignores_start"}, bus.busy, 1'b0);
        check({tag, "_held_q"}, bus.quotient, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        prev_q        = 32'd0;
        prev_r        = 32'd0;
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd0;
        bus.divisor   = 32'd0;
        #12;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_div_zero", bus.div_zero, 1'b0);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        run_op("s_7_2", 1'b1, 32'd7, 32'd2, -1);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, -1);
        run_op("u_ffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("s_ffff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, -1);
        run_op("u_by_zero", 1'b0, 32'h0000_1234, 32'd0, -1);
        run_op("s_by_zero", 1'b1, 32'hFFFF_0000, 32'd0, -1);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("s_poke", 1'b1, 32'd12345, 32'hFFFF_FFEF, 10);

        // clear in the middle of an operation
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_busy", bus.busy, 1'b0);
        check("clr_done", bus.done, 1'b0);
        check("clr_div_zero", bus.div_zero, 1'b0);
        check("clr_quotient", bus.quotient, 32'd0);
        check("clr_remainder", bus.remainder, 32'd0);
        @(negedge clk);
        clr    = 1'b0;
        prev_q = 32'd0;
        prev_r = 32'd0;
        repeat (3) @(negedge clk);
        check("clr_stays_idle", bus.busy, 1'b0);
        run_op("u_100_7", 1'b0, 32'd100, 32'd7, -1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] dd;
            logic [31:0] dv;
            dd = pick_operand();
            dv = pick_operand();
            run_op($sformatf("rnd%0d", i), 1'($urandom), dd, dv,
                   (i % 5 == 0) ? int'($urandom_range(0, 20)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
